ifetch_unit: RTL and testbench

//  Instruction-fetch initiator for the 32-bit MIPS core; the requesting end of the imem read port.

---
 rtl/ifetch_unit_pkg.sv | 22 ++
 rtl/ifetch_fifo.sv | 82 ++++++++
 rtl/ifetch_unit.sv | 104 ++++++++++
 tb/tb_ifetch_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch slice: bus widths, default reset PC
// and the {pc, instr} entry layout carried by the prefetch queue.
package ifetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Word-align a byte address by masking the two low bits.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous prefetch FIFO for fetched {pc, instr} entries.
// Flush has priority over push and pop; push while full is accepted only alongside a pop.
module ifetch_fifo
  import ifetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through a non-zero count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: PC register, imem request, prefetch queue and redirect handling.
// Optional misaligned-redirect fault/halt is enabled by defining IFETCH_ALIGN_CHECK_EN.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_plus4,
  output logic               fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted;
  logic              pop, push, push_room;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty, fifo_full;
  fetch_entry_t      wr_entry, head;

  assign imem_addr = pc_q;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid & out_ready;
  assign push_room = ((fifo_count < FULL_CNT) & !fifo_full) | pop;
  assign push      = !rst & !redirect_valid & !halted & push_room;
  assign wr_entry  = '{pc: pc_q, instr: imem_instr};

  assign out_instr    = out_valid ? head.instr : NOP_INSTR;
  assign out_pc       = out_valid ? head.pc : '0;
  assign out_pc_plus4 = out_valid ? head.pc + 32'd4 : '0;

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wr_entry),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Redirect outranks sequential fetch; the low target bits never reach the PC.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  // Each redirect re-evaluates the fault; a faulted unit stops fetching until then.
  always_comb begin
    fault_d = fault_q;
    if (redirect_valid) begin
      fault_d = (redirect_pc[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign halted      = fault_q;
  assign fetch_fault = fault_q;
`else
  assign halted      = 1'b0;
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: directed redirect/stall/reset sequences against a small imem image.
// Honours IFETCH_ALIGN_CHECK_EN for the misaligned-redirect scenario.
module tb_ifetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        fetch_fault;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  logic        have_prev_stall = 1'b0;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;

  ifetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .fetch_fault    (fetch_fault)
  );

  // Test program image; unlisted words return an address-tagged pattern.
  function automatic logic [31:0] rom(input logic [31:0] addr);
    logic [9:0] idx;
    idx = addr[11:2];
    case (idx)
      10'd0:   return 32'h2001_000A;
      10'd1:   return 32'h2002_0014;
      10'd2:   return 32'h0022_1820;
      10'd3:   return 32'h0062_2022;
      10'd4:   return 32'h0085_3025;
      10'd5:   return 32'h00A6_3822;
      10'd6:   return 32'hAC07_0000;
      10'd7:   return 32'h8C08_0004;
      10'd8:   return 32'h1000_FFFF;
      default: return 32'hC0DE_0000 | {22'h0, idx};
    endcase
  endfunction

  assign imem_instr = rom(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%08h expected=%08h", name, actual, expected);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = rom(pc);
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic r, input logic rv, input logic [31:0] rpc,
                                input logic rdy, input int n);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: scores every accepted head and checks stability across stalls.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (have_prev_stall) begin
          check_output("stall_valid", {31'h0, out_valid}, 32'h1);
          check_output("stall_pc", out_pc, prev_pc);
          check_output("stall_instr", out_instr, prev_instr);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_accept actual_pc=%08h expected=none", out_pc);
          end else begin
            e = exp_q.pop_front();
            check_output("sb_pc", out_pc, e.pc);
            check_output("sb_instr", out_instr, e.instr);
            check_output("sb_pc_plus4", out_pc_plus4, e.pc + 32'd4);
          end
        end
      end
      have_prev_stall = !rst && out_valid && !out_ready && !redirect_valid;
      prev_pc         = out_pc;
      prev_instr      = out_instr;
    end
  end

  initial begin
    // Reset state
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1, 2);
    check_output("rst_valid", {31'h0, out_valid}, 32'h0);
    check_output("rst_pc", out_pc, 32'h0);
    check_output("rst_instr", out_instr, 32'h0);
    check_output("rst_pc_plus4", out_pc_plus4, 32'h0);
    check_output("rst_imem_addr", imem_addr, 32'h0);
    check_output("rst_fault", {31'h0, fetch_fault}, 32'h0);

    // 1: streaming from reset
    expect_fetch(32'h0);
    expect_fetch(32'h4);
    expect_fetch(32'h8);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 4);

    // 2: stall after reset fills the queue, then drain
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 2);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1);
    check_output("fill_first_valid", {31'h0, out_valid}, 32'h1);
    check_output("fill_first_addr", imem_addr, 32'h4);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1);
      check_output("fill_addr_hold", imem_addr, 32'h8);
      check_output("fill_head_pc", out_pc, 32'h0);
      check_output("fill_head_instr", out_instr, 32'h2001_000A);
    end
    expect_fetch(32'h0);
    expect_fetch(32'h4);
    expect_fetch(32'h8);
    expect_fetch(32'hC);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 4);

    // 3: redirect to 0 while head is 0x1C
    expect_fetch(32'h10);
    expect_fetch(32'h14);
    expect_fetch(32'h18);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 3);
    check_output("pre_redirect_head", out_pc, 32'h1C);
    apply_stimulus(1'b0, 1'b1, 32'h0, 1'b0, 1);
    check_output("flush_valid", {31'h0, out_valid}, 32'h0);
    check_output("flush_addr", imem_addr, 32'h0);
    expect_fetch(32'h0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 2);

    // 4: redirect coinciding with a pop on a full queue
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1);
    check_output("full_head_pc", out_pc, 32'h4);
    check_output("full_addr", imem_addr, 32'hC);
    expect_fetch(32'h4);
    expect_fetch(32'h14);
    apply_stimulus(1'b0, 1'b1, 32'h14, 1'b1, 1);
    check_output("redir_pop_valid", {31'h0, out_valid}, 32'h0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 2);

    // 5: misaligned redirect
    apply_stimulus(1'b0, 1'b1, 32'h6, 1'b0, 1);
`ifdef IFETCH_ALIGN_CHECK_EN
    check_output("misalign_fault", {31'h0, fetch_fault}, 32'h1);
    check_output("misalign_valid", {31'h0, out_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1);
      check_output("halt_valid", {31'h0, out_valid}, 32'h0);
      check_output("halt_fault", {31'h0, fetch_fault}, 32'h1);
    end
    apply_stimulus(1'b0, 1'b1, 32'h10, 1'b1, 1);
    check_output("recover_fault", {31'h0, fetch_fault}, 32'h0);
    check_output("recover_valid", {31'h0, out_valid}, 32'h0);
    expect_fetch(32'h10);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 2);
`else
    check_output("misalign_fault", {31'h0, fetch_fault}, 32'h0);
    check_output("misalign_addr", imem_addr, 32'h4);
    expect_fetch(32'h4);
    expect_fetch(32'h8);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 3);
`endif

    // 6: PC wrap, then reset mid-stream with a redirect that must be ignored
    apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1);
    expect_fetch(32'hFFFF_FFFC);
    expect_fetch(32'h0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 3);
    apply_stimulus(1'b1, 1'b1, 32'h40, 1'b0, 1);
    check_output("midrst_valid", {31'h0, out_valid}, 32'h0);
    check_output("midrst_pc", out_pc, 32'h0);
    check_output("midrst_addr", imem_addr, 32'h0);
    expect_fetch(32'h0);
    expect_fetch(32'h4);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 3);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 2);

    check_output("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
